axis_frame_len_limit: RTL and testbench

- Single-clock AXI-Stream stage that sits directly downstream of axis_async_fifo in the output clock domain.
- Forwards frames unchanged when they are no longer than a programmable limit.
- Truncates oversize frames: the beat that reaches the limit is forced to tlast=1 and tuser=1, and the rest of that frame is discarded.
- Reports the length of each emitted frame and keeps a saturating count of truncation events.

---
 rtl/axis_frame_len_limit.sv | 91 +++++++++
 tb/tb_axis_frame_len_limit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_len_limit.sv
// AXI-Stream frame length limiter: passes frames up to max_len beats, truncates longer ones.
// Latency 1 through one output register; PASS stalls on output_axis_tready, DROP always accepts.
module axis_frame_len_limit #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  async_rst,
   input  logic [DATA_WIDTH-1:0] input_axis_tdata,
   input  logic                  input_axis_tvalid,
   output logic                  input_axis_tready,
   input  logic                  input_axis_tlast,
   input  logic                  input_axis_tuser,
   output logic [DATA_WIDTH-1:0] output_axis_tdata,
   output logic                  output_axis_tvalid,
   input  logic                  output_axis_tready,
   output logic                  output_axis_tlast,
   output logic                  output_axis_tuser,
   input  logic [LEN_WIDTH-1:0]  max_len,
   output logic [LEN_WIDTH-1:0]  frame_len,
   output logic                  frame_len_valid,
   output logic [LEN_WIDTH-1:0]  trunc_count
);

   typedef enum logic {PASS, DROP} state_t;

   state_t               state;
   logic [LEN_WIDTH-1:0] cnt;
   logic [LEN_WIDTH-1:0] lim;
   logic [LEN_WIDTH-1:0] lim_eff;
   logic [LEN_WIDTH-1:0] n;
   logic                 accept;

   // The first beat of a frame sees max_len directly; later beats use the latched copy.
   assign lim_eff = (cnt == '0) ? max_len : lim;
   assign n       = cnt + LEN_WIDTH'(1);

   assign input_axis_tready = (state == DROP) | output_axis_tready | ~output_axis_tvalid;
   assign accept            = input_axis_tvalid & input_axis_tready;

   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
         state              <= PASS;
         cnt                <= '0;
         lim                <= '0;
         output_axis_tdata  <= '0;
         output_axis_tvalid <= 1'b0;
         output_axis_tlast  <= 1'b0;
         output_axis_tuser  <= 1'b0;
         frame_len          <= '0;
         frame_len_valid    <= 1'b0;
         trunc_count        <= '0;
      end else begin
         frame_len_valid <= 1'b0;
         if (output_axis_tready)
            output_axis_tvalid <= 1'b0;

         if (accept) begin
            if (state == PASS) begin
               if (cnt == '0)
                  lim <= max_len;
               output_axis_tvalid <= 1'b1;
               output_axis_tdata  <= input_axis_tdata;
               output_axis_tlast  <= input_axis_tlast;
               output_axis_tuser  <= input_axis_tuser;
               if (input_axis_tlast) begin
                  frame_len       <= n;
                  frame_len_valid <= 1'b1;
                  cnt             <= '0;
               end else if (lim_eff != '0 && n == lim_eff) begin
                  output_axis_tlast <= 1'b1;
                  output_axis_tuser <= 1'b1;
                  frame_len         <= lim_eff;
                  frame_len_valid   <= 1'b1;
                  if (trunc_count != '1)
                     trunc_count <= trunc_count + LEN_WIDTH'(1);
                  cnt               <= '0;
                  state             <= DROP;
               end else begin
                  cnt <= n;
               end
            end else if (input_axis_tlast) begin
               // Tail of a truncated frame has been swallowed; resume forwarding.
               state <= PASS;
               cnt   <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_axis_frame_len_limit.sv
// Bench for axis_frame_len_limit: directed frames plus randomized traffic against a frame-level reference model.
module tb_axis_frame_len_limit;

   logic        clk = 1'b0;
   logic        async_rst;
   logic [7:0]  in_dat;
   logic        in_vld, in_rdy, in_last, in_user;
   logic [7:0]  out_dat;
   logic        out_vld, out_rdy, out_last, out_user;
   logic [15:0] max_len, frame_len, trunc_count;
   logic        frame_len_valid;

   always #5 clk = ~clk;

   axis_frame_len_limit #(.DATA_WIDTH(8), .LEN_WIDTH(16)) dut (
      .clk                (clk),
      .async_rst          (async_rst),
      .input_axis_tdata   (in_dat),
      .input_axis_tvalid  (in_vld),
      .input_axis_tready  (in_rdy),
      .input_axis_tlast   (in_last),
      .input_axis_tuser   (in_user),
      .output_axis_tdata  (out_dat),
      .output_axis_tvalid (out_vld),
      .output_axis_tready (out_rdy),
      .output_axis_tlast  (out_last),
      .output_axis_tuser  (out_user),
      .max_len            (max_len),
      .frame_len          (frame_len),
      .frame_len_valid    (frame_len_valid),
      .trunc_count        (trunc_count)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: whole frames are collected, then the expected output stream is derived at once.
   logic [9:0]  exp_q[$], obs_q[$];
   logic [15:0] exp_fl[$], obs_fl[$];
   logic [7:0]  cur_d[$];
   logic        cur_u[$];
   int          cur_lim, k, flen_n;
   logic [15:0] m_trunc = 16'd0;
   logic [15:0] lim_now;
   logic        drop_now, hit;
   logic        pend = 1'b0, prev_stall = 1'b0;
   logic [9:0]  pend_b, prev_b;

   always @(negedge clk) begin
      if (async_rst) begin
         cur_d.delete();
         cur_u.delete();
         pend       = 1'b0;
         prev_stall = 1'b0;
         m_trunc    = 16'd0;
         while (obs_q.size() > exp_q.size()) void'(obs_q.pop_back());
         while (obs_fl.size() > exp_fl.size()) void'(obs_fl.pop_back());
      end else begin
         if (pend) begin
            check_eq("lat_vld", 32'(out_vld), 32'd1);
            check_eq("lat_beat", 32'({out_last, out_user, out_dat}), 32'(pend_b));
            pend = 1'b0;
         end
         if (prev_stall) begin
            check_eq("stall_vld", 32'(out_vld), 32'd1);
            check_eq("stall_hold", 32'({out_last, out_user, out_dat}), 32'(prev_b));
         end
         prev_stall = out_vld && !out_rdy;
         prev_b     = {out_last, out_user, out_dat};
         if (frame_len_valid) begin
            check_eq("flv_align", 32'(out_vld && out_last), 32'd1);
            obs_fl.push_back(frame_len);
         end
         if (out_vld && out_rdy) obs_q.push_back({out_last, out_user, out_dat});

         k        = cur_d.size();
         lim_now  = (k == 0) ? max_len : 16'(cur_lim);
         drop_now = (k > 0) && (cur_lim != 0) && (k >= cur_lim);
         if (drop_now) check_eq("drop_rdy", 32'(in_rdy), 32'd1);
         else if (out_vld && !out_rdy) check_eq("stall_rdy", 32'(in_rdy), 32'd0);

         if (in_vld && in_rdy) begin
            if (k == 0) cur_lim = int'(max_len);
            if (!drop_now) begin
               hit    = (lim_now != 16'd0) && (k + 1 == int'(lim_now));
               pend   = 1'b1;
               pend_b = {in_last | hit, in_user | (hit & ~in_last), in_dat};
            end
            cur_d.push_back(in_dat);
            cur_u.push_back(in_user);
            if (in_last) begin
               flen_n = cur_d.size();
               if (cur_lim != 0 && flen_n > cur_lim) begin
                  for (int i = 0; i < cur_lim; i++)
                     exp_q.push_back({i == cur_lim - 1, (i == cur_lim - 1) ? 1'b1 : cur_u[i], cur_d[i]});
                  exp_fl.push_back(16'(cur_lim));
                  if (m_trunc != 16'hffff) m_trunc = m_trunc + 16'd1;
               end else begin
                  for (int i = 0; i < flen_n; i++)
                     exp_q.push_back({i == flen_n - 1, cur_u[i], cur_d[i]});
                  exp_fl.push_back(16'(flen_n));
               end
               cur_d.delete();
               cur_u.delete();
            end
         end
      end
   end

   // Downstream ready: 0 = always ready, 1 = repeating 1,0,0,1 pattern, 2 = random.
   int rdy_mode = 0;
   int pcnt = 0;
   always @(posedge clk) begin
      #1;
      pcnt = pcnt + 1;
      case (rdy_mode)
         1:       out_rdy = (pcnt % 4 == 0) || (pcnt % 4 == 3);
         2:       out_rdy = ($urandom_range(0, 3) != 0);
         default: out_rdy = 1'b1;
      endcase
   end

   task automatic send_beat(input logic [7:0] d, input logic u, input logic l);
      int  guard = 0;
      logic acc;
      in_vld = 1'b1; in_dat = d; in_user = u; in_last = l;
      do begin
         @(negedge clk);
         acc = in_vld && in_rdy;
         @(posedge clk); #1;
         guard++;
      end while (!acc && guard < 200);
      if (!acc) check_eq("accept_timeout", 32'(acc), 32'd1);
      in_vld = 1'b0;
   endtask

   task automatic send_frame(input int len, input logic [7:0] base);
      for (int i = 0; i < len; i++) send_beat(base + 8'(i), 1'b0, i == len - 1);
   endtask

   task automatic wait_idle();
      int g = 0;
      while (out_vld && g < 200) begin
         @(posedge clk); #1;
         g++;
      end
      if (out_vld) check_eq("drain_timeout", 32'(out_vld), 32'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_vld"}, 32'(out_vld), 32'd0);
      check_eq({tag, "_dat"}, 32'({out_last, out_user, out_dat}), 32'd0);
      check_eq({tag, "_flen"}, 32'(frame_len), 32'd0);
      check_eq({tag, "_flv"}, 32'(frame_len_valid), 32'd0);
      check_eq({tag, "_trunc"}, 32'(trunc_count), 32'd0);
   endtask

   initial begin
      async_rst = 1'b0; in_vld = 1'b0; in_dat = 8'd0; in_last = 1'b0; in_user = 1'b0;
      out_rdy = 1'b1; max_len = 16'd0;
      #2 async_rst = 1'b1;
      #1 check_outputs_zero("reset");
      repeat (2) @(posedge clk);
      #1 async_rst = 1'b0;
      check_eq("reset_in_rdy", 32'(in_rdy), 32'd1);

      // Short frame under the limit.
      max_len = 16'd4;
      send_beat(8'h11, 1'b0, 1'b0);
      send_beat(8'h22, 1'b0, 1'b0);
      send_beat(8'h33, 1'b0, 1'b1);
      wait_idle();
      check_eq("t1_flen", 32'(frame_len), 32'd3);
      check_eq("t1_trunc", 32'(trunc_count), 32'd0);

      // Oversize frame, then a frame ending exactly at the limit.
      send_frame(7, 8'h01);
      wait_idle();
      check_eq("t2_flen", 32'(frame_len), 32'd4);
      check_eq("t2_trunc", 32'(trunc_count), 32'd1);
      send_frame(4, 8'h41);
      wait_idle();
      check_eq("t3_flen", 32'(frame_len), 32'd4);
      check_eq("t3_trunc", 32'(trunc_count), 32'd1);

      // Back-pressure with no limit.
      rdy_mode = 1; max_len = 16'd0;
      send_frame(5, 8'h51);
      wait_idle();
      rdy_mode = 0;
      check_eq("t4_flen", 32'(frame_len), 32'd5);

      // Limit change mid-frame only affects the next frame.
      max_len = 16'd8;
      for (int i = 0; i < 6; i++) begin
         if (i == 2) max_len = 16'd2;
         send_beat(8'h61 + 8'(i), 1'b0, i == 5);
      end
      wait_idle();
      check_eq("t5a_flen", 32'(frame_len), 32'd6);
      check_eq("t5a_trunc", 32'(trunc_count), 32'd1);
      send_frame(6, 8'h71);
      wait_idle();
      check_eq("t5b_flen", 32'(frame_len), 32'd2);
      check_eq("t5b_trunc", 32'(trunc_count), 32'd2);

      // Reset in the middle of a frame.
      max_len = 16'd0;
      send_beat(8'h81, 1'b0, 1'b0);
      send_beat(8'h82, 1'b0, 1'b0);
      in_vld = 1'b1; in_dat = 8'h83; in_last = 1'b0;
      #2 async_rst = 1'b1;
      #1 check_outputs_zero("t6_rst");
      in_vld = 1'b0;
      @(posedge clk); #1 async_rst = 1'b0;
      send_frame(2, 8'h91);
      wait_idle();
      check_eq("t6_flen", 32'(frame_len), 32'd2);
      check_eq("t6_trunc", 32'(trunc_count), 32'd0);

      // Randomized traffic: gaps, random ready, limit changing under the frame.
      rdy_mode = 2;
      for (int f = 0; f < 60; f++) begin
         int len;
         len = $urandom_range(1, 10);
         for (int b = 0; b < len; b++) begin
            int gaps;
            gaps = $urandom_range(0, 2);
            if ($urandom_range(0, 9) < 3) begin
               case ($urandom_range(0, 5))
                  0: max_len = 16'd0;
                  1: max_len = 16'd1;
                  2: max_len = 16'd2;
                  3: max_len = 16'd3;
                  4: max_len = 16'd4;
                  default: max_len = 16'd6;
               endcase
            end
            repeat (gaps) begin
               @(posedge clk); #1;
            end
            send_beat(8'($urandom), $urandom_range(0, 3) == 0, b == len - 1);
         end
      end
      rdy_mode = 0;
      wait_idle();

      check_eq("final_trunc", 32'(trunc_count), 32'(m_trunc));
      check_eq("beat_count", 32'(obs_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
         check_eq($sformatf("beat_%0d", i), 32'(obs_q[i]), 32'(exp_q[i]));
      check_eq("flen_count", 32'(obs_fl.size()), 32'(exp_fl.size()));
      for (int i = 0; i < obs_fl.size() && i < exp_fl.size(); i++)
         check_eq($sformatf("flen_%0d", i), 32'(obs_fl[i]), 32'(exp_fl[i]));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
